// File: rtl/data_mmio_responder_pkg.sv
// Shared constants and types for the data-port MMIO responder.
// Holds the MMIO register offsets, STATUS bit positions and the TX serializer state type.
package mmio_pkg;

    localparam int DATA_W = 32;

    localparam logic [31:0] TX_DATA_OFS  = 32'h0000_0000;
    localparam logic [31:0] RX_DATA_OFS  = 32'h0000_0004;
    localparam logic [31:0] RX_POP_OFS   = 32'h0000_0008;
    localparam logic [31:0] STATUS_OFS   = 32'h0000_000C;
    localparam logic [31:0] LOOPBACK_OFS = 32'h0000_0010;

    localparam int STAT_TX_FULL     = 0;
    localparam int STAT_RX_NONEMPTY = 1;
    localparam int STAT_TX_BUSY     = 2;
    localparam int STAT_TX_OVF      = 3;
    localparam int STAT_RX_OVF      = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/data_mmio_responder_if.sv
// Core data-memory port bundle: write strobe, byte address, write data and
// the same-cycle read data returned by the responder.
interface data_mmio_responder_if;
    import mmio_pkg::*;

    logic              data_we;
    logic [DATA_W-1:0] data_addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] read_data;

    modport master (
        output data_we,
        output data_addr,
        output din,
        input  read_data
    );

    modport slave (
        input  data_we,
        input  data_addr,
        input  din,
        output read_data
    );

endinterface

// File: rtl/data_mmio_responder_sync_fifo.sv
// Small synchronous FIFO with a peekable head entry.
// A pop on an empty FIFO is ignored; a push into a full FIFO is accepted only
// when a real pop happens in the same cycle, otherwise it is dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage array is not reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_mmio_responder.sv
// Data-memory port responder: word RAM below MMIO_BASE, MMIO window above it
// holding a UART TX FIFO + 8N1 serializer and an RX FIFO fed by an external byte stream.
// Optional feature macro: MMIO_LOOPBACK_EN adds a LOOPBACK register at offset 0x10
// that routes every byte taken by the serializer into the RX FIFO.
module data_mmio_responder
    import mmio_pkg::*;
#(
    parameter int          RAM_WORDS    = 4096,
    parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mmio_responder_if.slave  bus,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    output logic                  txd,
    output logic                  irq_rx
);

    localparam int AW    = $clog2(RAM_WORDS);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [31:0] ram [RAM_WORDS];
    logic [AW-1:0] ram_idx;
    logic        is_mmio;
    logic [31:0] offset;
    logic [31:0] word_ofs;
    logic        unused_ofs_bits;

    logic        tx_wr;
    logic        rx_pop_wr;
    logic        status_wr;

    logic        tx_full;
    logic        tx_empty;
    logic [7:0]  tx_head;
    logic        tx_pop;

    logic        rx_push;
    logic [7:0]  rx_push_data;
    logic        rx_full;
    logic        rx_empty;
    logic [7:0]  rx_head;

    logic        tx_ovf;
    logic        rx_ovf;
    logic        tx_busy;
    logic [31:0] status_word;
    logic [31:0] mmio_rdata;

    tx_state_t   state_q;
    tx_state_t   state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]  bit_q;
    logic [2:0]  bit_d;
    logic [7:0]  shreg_q;
    logic [7:0]  shreg_d;
    logic        txd_d;
    logic        cnt_done;

    assign is_mmio         = (bus.data_addr >= MMIO_BASE);
    assign offset          = bus.data_addr - MMIO_BASE;
    assign word_ofs        = {offset[31:2], 2'b00};
    assign unused_ofs_bits = ^offset[1:0];
    assign ram_idx         = bus.data_addr[AW+1:2];

    assign tx_wr     = bus.data_we && is_mmio && (word_ofs == TX_DATA_OFS);
    assign rx_pop_wr = bus.data_we && is_mmio && (word_ofs == RX_POP_OFS);
    assign status_wr = bus.data_we && is_mmio && (word_ofs == STATUS_OFS);

    // Word RAM write port; upper address bits alias onto the same words.
    always_ff @(posedge clk) begin
        if (bus.data_we && !is_mmio) begin
            ram[ram_idx] <= bus.din;
        end
    end

`ifdef MMIO_LOOPBACK_EN
    logic loopback_q;
    logic lb_wr;

    assign lb_wr = bus.data_we && is_mmio && (word_ofs == LOOPBACK_OFS);

    // Loopback enable bit; while set the serializer feeds the RX FIFO instead of rx_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            loopback_q <= 1'b0;
        end else if (lb_wr) begin
            loopback_q <= bus.din[0];
        end
    end

    assign rx_push      = loopback_q ? tx_pop  : rx_valid;
    assign rx_push_data = loopback_q ? tx_head : rx_byte;
`else
    assign rx_push      = rx_valid;
    assign rx_push_data = rx_byte;
`endif

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_wr),
        .push_data (bus.din[7:0]),
        .pop       (tx_pop),
        .full      (tx_full),
        .empty     (tx_empty),
        .head      (tx_head)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_push_data),
        .pop       (rx_pop_wr),
        .full      (rx_full),
        .empty     (rx_empty),
        .head      (rx_head)
    );

    // Sticky overflow flags; a loss in the same cycle as a STATUS write stays visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (status_wr) begin
                tx_ovf <= 1'b0;
                rx_ovf <= 1'b0;
            end
            if (tx_wr && tx_full && !tx_pop) begin
                tx_ovf <= 1'b1;
            end
            if (rx_push && rx_full && !rx_pop_wr) begin
                rx_ovf <= 1'b1;
            end
        end
    end

    assign cnt_done = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Serializer next state; txd is registered one cycle behind the state it describes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_pop  = 1'b0;
        txd_d   = 1'b1;
        case (state_q)
            IDLE: begin
                if (!tx_empty) begin
                    tx_pop  = 1'b1;
                    shreg_d = tx_head;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                txd_d = 1'b0;
                if (cnt_done) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                txd_d = shreg_q[bit_q];
                if (cnt_done) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_done) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Serializer registers; reset drops any frame in flight and idles the line high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            txd     <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            txd     <= txd_d;
        end
    end

    assign tx_busy = (state_q != IDLE) || !tx_empty;
    assign irq_rx  = !rx_empty;

    // STATUS word assembly.
    always_comb begin
        status_word                   = '0;
        status_word[STAT_TX_FULL]     = tx_full;
        status_word[STAT_RX_NONEMPTY] = !rx_empty;
        status_word[STAT_TX_BUSY]     = tx_busy;
        status_word[STAT_TX_OVF]      = tx_ovf;
        status_word[STAT_RX_OVF]      = rx_ovf;
    end

    // MMIO read mux; write-only and unmapped offsets read as zero.
    always_comb begin
        mmio_rdata = '0;
        case (word_ofs)
            RX_DATA_OFS: mmio_rdata = rx_empty ? 32'h0 : {24'h0, rx_head};
            STATUS_OFS:  mmio_rdata = status_word;
`ifdef MMIO_LOOPBACK_EN
            LOOPBACK_OFS: mmio_rdata = {31'h0, loopback_q};
`endif
            default:     mmio_rdata = '0;
        endcase
    end

    assign bus.read_data = is_mmio ? mmio_rdata : ram[ram_idx];

endmodule

// File: tb/tb_data_mmio_responder.sv
// Scoreboard bench for data_mmio_responder with CLKS_PER_BIT=4, FIFO_DEPTH=16.
// Stimulus pushes expected values into queues; a negedge monitor drains and compares them.
module tb_data_mmio_responder;

   localparam logic [31:0] BASE   = 32'hFFFF_0000;
   localparam logic [31:0] A_TX   = BASE + 32'h0;
   localparam logic [31:0] A_RX   = BASE + 32'h4;
   localparam logic [31:0] A_POP  = BASE + 32'h8;
   localparam logic [31:0] A_STAT = BASE + 32'hC;
   localparam logic [31:0] A_LB   = BASE + 32'h10;

   localparam int K_RD  = 0;
   localparam int K_TXD = 1;
   localparam int K_IRQ = 2;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] rxByte;
   logic       rxValid;
   logic       txd;
   logic       irqRx;

   int          nVec  = 0;
   int          nMiss = 0;
   int          kindQ[$];
   logic [31:0] valQ[$];
   string       nameQ[$];

   int          monKind;
   logic [31:0] monAct;
   logic [31:0] monExp;
   string       monName;

   data_mmio_responder_if bus();

   data_mmio_responder #(
      .RAM_WORDS    (4096),
      .MMIO_BASE    (BASE),
      .FIFO_DEPTH   (16),
      .CLKS_PER_BIT (4)
   ) dut (
      .clk      (clock),
      .rst      (reset),
      .bus      (bus.slave),
      .rx_byte  (rxByte),
      .rx_valid (rxValid),
      .txd      (txd),
      .irq_rx   (irqRx)
   );

   // Free-running clock with a 10-unit period.
   always #5 clock = ~clock;

   // One bus cycle: inputs change just after the rising edge and are sampled at the next one.
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                input logic rxv, input logic [7:0] rxb);
      @(posedge clock);
      #1;
      bus.data_we   = we;
      bus.data_addr = addr;
      bus.din       = wd;
      rxValid       = rxv;
      rxByte        = rxb;
   endtask

   // Queue an expectation for the cycle currently being driven.
   task automatic checkOutput(input int kind, input logic [31:0] val, input string name);
      kindQ.push_back(kind);
      valQ.push_back(val);
      nameQ.push_back(name);
   endtask

   // Single bus write cycle with no RX activity.
   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      applyStimulus(1'b1, addr, data, 1'b0, 8'h00);
   endtask

   // Single bus read cycle with a queued read_data expectation.
   task automatic rd(input logic [31:0] addr, input logic [31:0] expVal, input string name);
      applyStimulus(1'b0, addr, 32'h0, 1'b0, 8'h00);
      checkOutput(K_RD, expVal, name);
   endtask

   // Monitor: compare every queued expectation against the DUT mid-cycle.
   always @(negedge clock) begin
      while (kindQ.size() > 0) begin
         monKind = kindQ.pop_front();
         monExp  = valQ.pop_front();
         monName = nameQ.pop_front();
         case (monKind)
            K_TXD:   monAct = {31'h0, txd};
            K_IRQ:   monAct = {31'h0, irqRx};
            default: monAct = bus.read_data;
         endcase
         nVec++;
         if (monAct !== monExp) begin
            nMiss++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", monName, monAct, monExp);
         end
      end
   end

   // Watchdog against a hung simulation.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no completion, want finish before timeout");
      $fatal(1);
   end

   // Main stimulus sequence.
   initial begin
      logic [7:0] b55;
      logic [31:0] expBit;
      int b;
      b55 = 8'h55;

      reset         = 1'b0;
      bus.data_we   = 1'b0;
      bus.data_addr = 32'h0;
      bus.din       = 32'h0;
      rxValid       = 1'b0;
      rxByte        = 8'h00;

      applyStimulus(1'b0, A_STAT, 32'h0, 1'b0, 8'h00);
      checkOutput(K_RD,  32'h0, "reset_status");
      checkOutput(K_TXD, 32'h1, "reset_txd");
      checkOutput(K_IRQ, 32'h0, "reset_irq");
      applyStimulus(1'b0, A_STAT, 32'h0, 1'b0, 8'h00);
      reset = 1'b1;

      wr(32'h0000_0100, 32'hDEAD_BEEF);
      rd(32'h0000_0100, 32'hDEAD_BEEF, "ram_rd");
      #1;
      nVec++;
      if (bus.read_data !== 32'hDEAD_BEEF) begin
         nMiss++;
         $display("[TB] FAIL ram_rd_direct: got 0x%08h, want 0x%08h", bus.read_data, 32'hDEAD_BEEF);
      end
      rd(32'h0000_4100, 32'hDEAD_BEEF, "ram_alias_rd");
      #1;
      nVec++;
      if (bus.read_data !== 32'hDEAD_BEEF) begin
         nMiss++;
         $display("[TB] FAIL ram_alias_direct: got 0x%08h, want 0x%08h", bus.read_data, 32'hDEAD_BEEF);
      end
      wr(32'h0000_0104, 32'h1234_5678);
      rd(32'h0000_0104, 32'h1234_5678, "ram_rd_next");
      rd(32'h0000_0100, 32'hDEAD_BEEF, "ram_no_clobber");
      wr(32'h0000_4100, 32'hCAFE_F00D);
      rd(32'h0000_0100, 32'hCAFE_F00D, "ram_alias_wr");

      wr(A_LB, 32'hFFFF_FFFE);
      rd(A_LB, 32'h0, "unmapped_0x10");
      rd(BASE + 32'h20, 32'h0, "unmapped_0x20");
      rd(A_TX, 32'h0, "tx_data_reads_0");
      rd(A_POP, 32'h0, "rx_pop_reads_0");

      wr(A_TX, 32'h0000_0055);
      for (int t = 1; t <= 44; t++) begin
         applyStimulus(1'b0, A_STAT, 32'h0, 1'b0, 8'h00);
         if (t == 1)  checkOutput(K_RD, 32'h4, "busy_after_write");
         if (t == 2)  checkOutput(K_TXD, 32'h1, "tx_pre_start");
         if (t == 3)  checkOutput(K_TXD, 32'h0, "tx_start_edge");
         if (t >= 4 && t <= 40 && (t % 4) == 0) begin
            b = (t - 4) / 4;
            if (b == 0)      expBit = 32'h0;
            else if (b == 9) expBit = 32'h1;
            else             expBit = {31'h0, b55[b-1]};
            checkOutput(K_TXD, expBit, $sformatf("tx_bit%0d", b));
         end
         if (t == 20) checkOutput(K_RD, 32'h4, "status_busy_mid");
         if (t == 41) checkOutput(K_RD, 32'h4, "busy_last_stop");
         if (t == 42) checkOutput(K_RD, 32'h0, "busy_clear");
      end

      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b0, A_STAT, 32'h0, 1'b1, 8'(i));
      end
      applyStimulus(1'b0, A_STAT, 32'h0, 1'b0, 8'h00);
      checkOutput(K_RD,  32'h12, "rx_ovf_status");
      checkOutput(K_IRQ, 32'h1,  "irq_rx_set");
      rd(A_RX, 32'h00, "rx_head0");
      #1;
      nVec++;
      if (bus.read_data !== 32'h0000_0000) begin
         nMiss++;
         $display("[TB] FAIL rx_head0_direct: got 0x%08h, want 0x%08h", bus.read_data, 32'h0);
      end
      wr(A_POP, 32'h0);
      rd(A_RX, 32'h01, "rx_head_after_pop");
      wr(A_STAT, 32'h0);
      rd(A_STAT, 32'h02, "rx_ovf_cleared");

      applyStimulus(1'b0, A_STAT, 32'h0, 1'b1, 8'h20);
      rd(A_STAT, 32'h02, "rx_full_no_ovf");
      applyStimulus(1'b1, A_POP, 32'h0, 1'b1, 8'h21);
      rd(A_STAT, 32'h02, "rx_full_push_pop");
      rd(A_RX, 32'h02, "rx_head_after_pp");
      applyStimulus(1'b0, A_STAT, 32'h0, 1'b1, 8'h22);
      rd(A_STAT, 32'h12, "rx_still_full");

      for (int i = 0; i < 14; i++) begin
         wr(A_POP, 32'h0);
      end
      rd(A_RX, 32'h20, "rx_head_0x20");
      wr(A_POP, 32'h0);
      rd(A_RX, 32'h21, "rx_head_0x21");
      wr(A_POP, 32'h0);
      rd(A_RX, 32'h00, "rx_empty_read");
      checkOutput(K_IRQ, 32'h0, "irq_rx_clear");
      wr(A_POP, 32'h0);
      applyStimulus(1'b0, A_STAT, 32'h0, 1'b1, 8'h33);
      rd(A_RX, 32'h33, "rx_after_empty_pop");
      wr(A_POP, 32'h0);
      applyStimulus(1'b1, A_POP, 32'h0, 1'b1, 8'h44);
      rd(A_RX, 32'h44, "rx_empty_push_pop");
      wr(A_POP, 32'h0);
      wr(A_STAT, 32'h0);
      rd(A_STAT, 32'h0, "status_all_clear");

      for (int i = 0; i < 17; i++) begin
         wr(A_TX, 32'h80 + 32'(i));
      end
      rd(A_STAT, 32'h05, "tx_full_no_ovf");
      wr(A_TX, 32'h91);
      rd(A_STAT, 32'h0D, "tx_ovf_set");

      applyStimulus(1'b0, A_STAT, 32'h0, 1'b0, 8'h00);
      applyStimulus(1'b0, A_STAT, 32'h0, 1'b0, 8'h00);
      checkOutput(K_TXD, 32'h0, "txd_mid_data");
      applyStimulus(1'b0, A_STAT, 32'h0, 1'b0, 8'h00);
      reset = 1'b0;
      checkOutput(K_TXD, 32'h1, "txd_reset_abort");
      checkOutput(K_RD,  32'h0, "status_in_reset");
      applyStimulus(1'b0, A_STAT, 32'h0, 1'b0, 8'h00);
      reset = 1'b1;
      rd(A_STAT, 32'h0, "status_after_reset");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, A_STAT, 32'h0, 1'b0, 8'h00);
      end
      checkOutput(K_TXD, 32'h1, "txd_idle_after_reset");
      rd(A_RX, 32'h0, "rx_empty_after_reset");

`ifdef MMIO_LOOPBACK_EN
      wr(A_LB, 32'h1);
      rd(A_LB, 32'h1, "lb_readback");
      wr(A_TX, 32'hA5);
      applyStimulus(1'b0, A_STAT, 32'h0, 1'b0, 8'h00);
      applyStimulus(1'b0, A_RX, 32'h0, 1'b0, 8'h00);
      checkOutput(K_RD,  32'hA5, "lb_rx_data");
      checkOutput(K_IRQ, 32'h1,  "lb_irq_rx");
`endif

      applyStimulus(1'b0, A_STAT, 32'h0, 1'b0, 8'h00);
      @(negedge clock);
      #1;
      if (nMiss != 0) begin
         $display("[TB] FAIL summary: got %0d miscompares, want 0", nMiss);
      end
      $display("[TB] == %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule
